// File: rtl/dqsw_lane_train_ctrl.sv
// DQSW write-levelling sweep controller. Steps each lane's delay line tap by tap and
// records the first tap where the majority-voted EYE_MONITOR_LATE rises from 0 to 1.
module dqsw_lane_train_ctrl #(
    parameter int NUM_LANES     = 2,
    parameter int TAP_BITS      = 7,
    parameter int MAX_TAPS      = 127,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 4
) (
    input  logic                          FAB_CLK,
    input  logic                          RESET,
    input  logic                          TRAIN_START,
    output logic                          TRAIN_BUSY,
    output logic                          TRAIN_DONE,
    output logic [NUM_LANES-1:0]          LANE_PASS,
    output logic [NUM_LANES*TAP_BITS-1:0] LANE_TAP,
    output logic [NUM_LANES-1:0]          DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]          DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]          DELAY_LINE_DIRECTION,
    input  logic [NUM_LANES-1:0]          DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0]          EYE_MONITOR_CLEAR_FLAGS,
    input  logic [NUM_LANES-1:0]          EYE_MONITOR_LATE,
    input  logic [NUM_LANES-1:0]          EYE_MONITOR_EARLY
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int SW = $clog2(SAMPLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CLEAR, S_SAMPLE, S_STEP, S_FAIL, S_NEXT
    } state_t;

    state_t                        r_state;
    logic [LW-1:0]                 r_lane;
    logic [TAP_BITS-1:0]           r_tap;
    logic                          r_prev;
    logic                          r_oor;
    logic [CW-1:0]                 r_settle_cnt;
    logic [SW-1:0]                 r_sample_cnt;
    logic [SW-1:0]                 r_ones;
    logic [NUM_LANES-1:0]          r_pass;
    logic [NUM_LANES*TAP_BITS-1:0] r_lane_tap;
    logic [NUM_LANES-1:0]          r_load;
    logic [NUM_LANES-1:0]          r_move;
    logic [NUM_LANES-1:0]          r_dir;
    logic [NUM_LANES-1:0]          r_clear;
    logic                          r_busy;
    logic                          r_done;

    logic [NUM_LANES-1:0] w_lane_sel;
    logic [NUM_LANES-1:0] w_next_sel;
    logic [SW-1:0]        w_ones_final;
    logic                 w_cur;
    logic                 w_oor_seen;
    logic                 w_last_sample;
    logic                 w_last_lane;
    logic                 w_unused;

    // EARLY is reserved for later training modes.
    assign w_unused = ^EYE_MONITOR_EARLY;

    always_comb begin
        w_lane_sel         = '0;
        w_lane_sel[r_lane] = 1'b1;
        w_next_sel         = w_lane_sel << 1;
        w_ones_final       = r_ones + SW'(EYE_MONITOR_LATE[r_lane]);
        w_cur              = {w_ones_final, 1'b0} > (SW+1)'(SAMPLES);
        w_oor_seen         = r_oor | DELAY_LINE_OUT_OF_RANGE[r_lane];
        w_last_sample      = (r_sample_cnt == SW'(SAMPLES - 1));
        w_last_lane        = (r_lane == LW'(NUM_LANES - 1));
    end

    // NOTE: reset is sampled on the clock edge, so an abort takes effect on the next edge.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_lane       <= '0;
            r_tap        <= '0;
            r_prev       <= 1'b0;
            r_oor        <= 1'b0;
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_ones       <= '0;
            r_pass       <= '0;
            r_lane_tap   <= '0;
            r_load       <= '0;
            r_move       <= '0;
            r_dir        <= '0;
            r_clear      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle; only the branch that wants one sets it.
            r_load  <= '0;
            r_move  <= '0;
            r_clear <= '0;
            r_done  <= 1'b0;
            // Out-of-range is sticky from the last LOAD/MOVE up to the sample decision.
            r_oor   <= (r_state == S_LOAD || r_state == S_STEP) ? 1'b0 : w_oor_seen;

            case (r_state)
                S_IDLE: begin
                    if (TRAIN_START) begin
                        r_state    <= S_LOAD;
                        r_pass     <= '0;
                        r_lane_tap <= '0;
                        r_load     <= w_lane_sel;
                        r_dir      <= w_lane_sel;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_tap        <= '0;
                    r_prev       <= 1'b0;
                    r_settle_cnt <= '0;
                    r_state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle_cnt == CW'(SETTLE_CYCLES - 1)) begin
                        r_settle_cnt <= '0;
                        r_clear      <= w_lane_sel;
                        r_state      <= S_CLEAR;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + CW'(1);
                    end
                end
                S_CLEAR: begin
                    r_sample_cnt <= '0;
                    r_ones       <= '0;
                    r_state      <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (!w_last_sample) begin
                        r_sample_cnt <= r_sample_cnt + SW'(1);
                        r_ones       <= w_ones_final;
                    end else if (w_cur && !r_prev && (r_tap != '0)) begin
                        // Edge found: the delay line is deliberately left at this tap.
                        r_pass[r_lane]                          <= 1'b1;
                        r_lane_tap[r_lane*TAP_BITS +: TAP_BITS] <= r_tap;
                        r_done                                  <= w_last_lane;
                        r_state                                 <= S_NEXT;
                    end else if ((r_tap == TAP_BITS'(MAX_TAPS)) || w_oor_seen) begin
                        r_load  <= w_lane_sel;
                        r_state <= S_FAIL;
                    end else begin
                        r_prev  <= w_cur;
                        r_move  <= w_lane_sel;
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_tap        <= r_tap + TAP_BITS'(1);
                    r_settle_cnt <= '0;
                    r_state      <= S_SETTLE;
                end
                S_FAIL: begin
                    r_pass[r_lane]                          <= 1'b0;
                    r_lane_tap[r_lane*TAP_BITS +: TAP_BITS] <= '0;
                    r_done                                  <= w_last_lane;
                    r_state                                 <= S_NEXT;
                end
                S_NEXT: begin
                    if (w_last_lane) begin
                        r_lane  <= '0;
                        r_dir   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_lane  <= r_lane + LW'(1);
                        r_load  <= w_next_sel;
                        r_dir   <= w_next_sel;
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign TRAIN_BUSY              = r_busy;
    assign TRAIN_DONE              = r_done;
    assign LANE_PASS               = r_pass;
    assign LANE_TAP                = r_lane_tap;
    assign DELAY_LINE_LOAD         = r_load;
    assign DELAY_LINE_MOVE         = r_move;
    assign DELAY_LINE_DIRECTION    = r_dir;
    assign EYE_MONITOR_CLEAR_FLAGS = r_clear;
endmodule

// File: tb/tb_dqsw_lane_train_ctrl.sv
// Bench for dqsw_lane_train_ctrl: behavioural delay-line/eye-monitor environment, a sweep
// reference model computed from per-tap LATE patterns, and a scoreboard checked on TRAIN_DONE.
module tb_dqsw_lane_train_ctrl;
    localparam int NL         = 2;
    localparam int TB         = 7;
    localparam int MAXT       = 127;
    localparam int SETTLE     = 8;
    localparam int SAMP       = 4;
    localparam int TAP_PERIOD = 1 + SETTLE + 1 + SAMP;

    logic              FAB_CLK     = 1'b0;
    logic              RESET       = 1'b1;
    logic              TRAIN_START = 1'b0;
    logic              TRAIN_BUSY;
    logic              TRAIN_DONE;
    logic [NL-1:0]     LANE_PASS;
    logic [NL*TB-1:0]  LANE_TAP;
    logic [NL-1:0]     DELAY_LINE_LOAD;
    logic [NL-1:0]     DELAY_LINE_MOVE;
    logic [NL-1:0]     DELAY_LINE_DIRECTION;
    logic [NL-1:0]     DELAY_LINE_OUT_OF_RANGE = '0;
    logic [NL-1:0]     EYE_MONITOR_CLEAR_FLAGS;
    logic [NL-1:0]     EYE_MONITOR_LATE  = '0;
    logic [NL-1:0]     EYE_MONITOR_EARLY = '0;

    dqsw_lane_train_ctrl #(
        .NUM_LANES(NL), .TAP_BITS(TB), .MAX_TAPS(MAXT),
        .SETTLE_CYCLES(SETTLE), .SAMPLES(SAMP)
    ) dut (
        .FAB_CLK(FAB_CLK),
        .RESET(RESET),
        .TRAIN_START(TRAIN_START),
        .TRAIN_BUSY(TRAIN_BUSY),
        .TRAIN_DONE(TRAIN_DONE),
        .LANE_PASS(LANE_PASS),
        .LANE_TAP(LANE_TAP),
        .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
        .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
        .EYE_MONITOR_LATE(EYE_MONITOR_LATE),
        .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    typedef struct packed {
        logic [NL-1:0]    pass;
        logic [NL*TB-1:0] taps;
        logic [NL*TB-1:0] pos;
        logic [NL*16-1:0] moves;
        logic [NL*16-1:0] loads;
    } exp_t;

    typedef struct packed {
        logic          pass;
        logic [TB-1:0] tap;
        logic [15:0]   moves;
        logic [15:0]   loads;
    } lane_res_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-lane, per-tap LATE pattern: bit s is the level presented in sample s of the window.
    logic [SAMP-1:0] pat [NL][128];
    int              oor_thr [NL];
    int              dl_tap [NL];
    int              sidx [NL];
    int              last_evt [NL];
    int              moves_total [NL];
    int              loads_total [NL];
    int              cyc = 0;
    logic            prev_done = 1'b0;
    exp_t            sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference sweep: walk taps from 0, majority-vote each window, first 0->1 above tap 0 wins.
    function automatic lane_res_t ref_lane(input int l);
        lane_res_t r;
        bit        prev;
        bit        cur;
        r    = '0;
        prev = 1'b0;
        for (int t = 0; t <= MAXT; t++) begin
            cur = (2 * $countones(pat[l][t])) > SAMP;
            if (cur && !prev && t != 0) begin
                r.pass  = 1'b1;
                r.tap   = TB'(t);
                r.moves = 16'(t);
                r.loads = 16'd1;
                return r;
            end
            if (t == MAXT || t >= oor_thr[l]) begin
                r.moves = 16'(t);
                r.loads = 16'd2;
                return r;
            end
            prev = cur;
        end
        return r;
    endfunction

    function automatic logic [SAMP-1:0] rand_pat(input bit hi);
        logic [SAMP-1:0] p;
        do p = SAMP'($urandom); while (((2 * $countones(p)) > SAMP) != hi);
        return p;
    endfunction

    task automatic set_step(input int l, input int edge_tap);
        for (int t = 0; t < 128; t++) pat[l][t] = (t >= edge_tap) ? '1 : '0;
        oor_thr[l] = 1000;
    endtask

    // Environment: delay-line position, sample window position, LATE/OOR drive.
    initial begin
        for (int l = 0; l < NL; l++) begin
            dl_tap[l] = 0; sidx[l] = 100; last_evt[l] = -1000;
            moves_total[l] = 0; loads_total[l] = 0; oor_thr[l] = 1000;
        end
    end

    always @(negedge FAB_CLK) begin : env
        logic [NL-1:0]   late_v;
        logic [NL-1:0]   oor_v;
        logic [SAMP-1:0] p;
        cyc++;
        for (int l = 0; l < NL; l++) begin
            if (DELAY_LINE_LOAD[l]) begin
                dl_tap[l] = 0;
                loads_total[l]++;
                last_evt[l] = cyc;
            end
            if (DELAY_LINE_MOVE[l]) begin
                check("move_spacing", 32'(cyc - last_evt[l]), 32'(TAP_PERIOD));
                if (dl_tap[l] < MAXT) dl_tap[l]++;
                moves_total[l]++;
                last_evt[l] = cyc;
            end
            if (EYE_MONITOR_CLEAR_FLAGS[l]) begin
                check("clear_spacing", 32'(cyc - last_evt[l]), 32'(1 + SETTLE));
                sidx[l] = -1;
            end else if (sidx[l] < 1000) begin
                sidx[l]++;
            end
            p         = pat[l][dl_tap[l]];
            late_v[l] = (sidx[l] >= 0 && sidx[l] < SAMP) ? p[sidx[l]] : 1'b0;
            oor_v[l]  = (dl_tap[l] >= oor_thr[l]);
        end
        EYE_MONITOR_LATE        = late_v;
        DELAY_LINE_OUT_OF_RANGE = oor_v;
        EYE_MONITOR_EARLY       = NL'($urandom);
    end

    // Monitor: per-cycle lane control sanity plus scoreboard pop on TRAIN_DONE.
    always @(negedge FAB_CLK) begin : monitor
        exp_t e;
        if (TRAIN_BUSY)
            check("lane_ctl", 32'({$countones(DELAY_LINE_DIRECTION) == 1,
                  ((DELAY_LINE_LOAD | DELAY_LINE_MOVE | EYE_MONITOR_CLEAR_FLAGS) & ~DELAY_LINE_DIRECTION) == '0}),
                  32'(2'b11));
        else
            check("idle_ctl", 32'({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                  EYE_MONITOR_CLEAR_FLAGS, TRAIN_DONE}), 32'(0));
        if (TRAIN_DONE) begin
            check("done_single_cycle", 32'(prev_done), 32'(0));
            if (sb_q.size() == 0) begin
                check("done_expected", 32'(sb_q.size()), 32'(1));
            end else begin
                e = sb_q.pop_front();
                check("lane_pass", 32'(LANE_PASS), 32'(e.pass));
                check("lane_tap", 32'(LANE_TAP), 32'(e.taps));
                for (int l = 0; l < NL; l++) begin
                    check("lane_moves", 32'(moves_total[l]), 32'(e.moves[l*16 +: 16]));
                    check("lane_loads", 32'(loads_total[l]), 32'(e.loads[l*16 +: 16]));
                    check("lane_final_pos", 32'(dl_tap[l]), 32'(e.pos[l*TB +: TB]));
                end
            end
        end
        prev_done = TRAIN_DONE;
    end

    task automatic run_sweep(input string tag);
        exp_t      e;
        lane_res_t r;
        bit        got;
        e = '0;
        for (int l = 0; l < NL; l++) begin
            r = ref_lane(l);
            e.pass[l]              = r.pass;
            e.taps[l*TB +: TB]     = r.pass ? r.tap : '0;
            e.pos[l*TB +: TB]      = r.pass ? r.tap : '0;
            e.moves[l*16 +: 16]    = 16'(moves_total[l]) + r.moves;
            e.loads[l*16 +: 16]    = 16'(loads_total[l]) + r.loads;
        end
        sb_q.push_back(e);
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        check({tag, "_first_load"}, 32'({TRAIN_BUSY, DELAY_LINE_LOAD}), 32'({1'b1, NL'(1)}));
        got = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge FAB_CLK);
            if (TRAIN_DONE) begin
                got = 1'b1;
                break;
            end
            TRAIN_START = ($urandom_range(0, 299) == 0);
        end
        check({tag, "_done_seen"}, 32'(got), 32'(1));
        if (!got) begin
            sb_q.delete();
            TRAIN_START = 1'b0;
            return;
        end
        // A start coinciding with TRAIN_DONE must not launch another sweep.
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        check({tag, "_idle_after_done"}, 32'({TRAIN_BUSY, DELAY_LINE_LOAD}), 32'(0));
        @(negedge FAB_CLK);
        check({tag, "_still_idle"}, 32'(TRAIN_BUSY), 32'(0));
    endtask

    initial begin : stim
        bit got;
        for (int l = 0; l < NL; l++) set_step(l, 200);
        repeat (3) @(negedge FAB_CLK);
        check("reset_state", 32'({TRAIN_BUSY, TRAIN_DONE, LANE_PASS, LANE_TAP, DELAY_LINE_LOAD,
              DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS}), 32'(0));
        RESET = 1'b0;
        @(negedge FAB_CLK);

        // Clean edges at 5 and 9.
        set_step(0, 5); set_step(1, 9);
        run_sweep("edges_5_9");

        // Lane 0 never rises: full sweep then fail.
        set_step(0, 200); set_step(1, 9);
        run_sweep("stuck_low");

        // Lane 0 runs out of range at tap 40.
        set_step(0, 200); oor_thr[0] = 40; set_step(1, 12);
        run_sweep("out_of_range");

        // High at tap 0 only seeds the previous level; edge lands at tap 3.
        set_step(0, 3); pat[0][0] = '1; set_step(1, 2);
        run_sweep("tap0_high");

        // Two ones out of four is not a majority; three is.
        set_step(0, 8); pat[0][6] = 4'b0101; pat[0][7] = 4'b0111; set_step(1, 3);
        run_sweep("majority");

        // Abort mid-sweep with reset, then a fresh sweep.
        set_step(0, 60); set_step(1, 4);
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge FAB_CLK);
            if (dl_tap[0] >= 20) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_reached_tap20", 32'(got), 32'(1));
        RESET = 1'b1;
        @(negedge FAB_CLK);
        RESET = 1'b0;
        check("abort_outputs_zero", 32'({TRAIN_BUSY, TRAIN_DONE, LANE_PASS, LANE_TAP, DELAY_LINE_LOAD,
              DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS}), 32'(0));
        @(negedge FAB_CLK);
        run_sweep("after_abort");

        // Randomised noisy eyes with occasional out-of-range.
        for (int k = 0; k < 6; k++) begin
            for (int l = 0; l < NL; l++) begin
                int e_tap;
                e_tap = $urandom_range(1, 40);
                for (int t = 0; t < 128; t++) pat[l][t] = rand_pat(t >= e_tap);
                oor_thr[l] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 45) : 1000;
            end
            run_sweep("random");
        end

        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
